phosphor_tap_scheduler: RTL and testbench

Downstream consumer of the 8-tap phosphor pixel ring buffer. It captures one 8-tap snapshot (256 bits) and applies a per-tap linear luma decay. It then serializes the surviving pixels, one per cycle, onto a valid/ready write stream toward the framebuffer blender. This converts the ring buffer's parallel tap bus into the framebuffer's single-pixel write port.

---
 rtl/phosphor_tap_scheduler.sv | 132 +++++++++++++
 tb/tb_phosphor_tap_scheduler.sv | 255 +++++++++++++++++++++++++
 2 files changed

// File: rtl/phosphor_tap_scheduler.sv
// phosphor_tap_scheduler: decays one 8-tap ring-buffer snapshot and streams it out.
// Optional macro PHOSPHOR_SKIP_DIM_EN drops entries whose decayed luma is below LUMA_MIN.
module phosphor_tap_scheduler #(
    parameter logic [11:0] LUMA_MIN = 12'd16,
    parameter int          DROP_W   = 16
) (
    input  logic              clock,
    input  logic              reset_n,
    input  logic [255:0]      taps,
    input  logic              tap_valid,
    output logic              tap_ready,
    output logic [31:0]       out_pixel,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DROP_W-1:0] drop_count
);

    typedef enum logic {IDLE, EMIT} state_t;

    state_t          state_q, state_d;
    logic [7:0]      mask_q, mask_d;
    logic [7:0][31:0] pix_q, pix_d;
    logic [31:0]     out_pixel_d;
    logic            out_valid_d;
    logic [7:0]      load_keep;
    logic [7:0][31:0] load_pix;
    logic [7:0]      remain;
    logic            handshake;

    function automatic logic [2:0] lowest(input logic [7:0] m);
        logic [2:0] idx;
        idx = '0;
        for (int i = 7; i >= 0; i--) begin
            if (m[i]) idx = 3'(i);
        end
        return idx;
    endfunction

`ifndef PHOSPHOR_SKIP_DIM_EN
    // LUMA_MIN only matters when dim skipping is compiled in.
    logic unused_luma_min;
    assign unused_luma_min = ^LUMA_MIN;
`endif

    assign tap_ready = (state_q == IDLE);
    assign handshake = out_valid && out_ready;

    // Per-tap linear decay and keep mask, evaluated on the incoming taps.
    always_comb begin
        logic [14:0] prod;
        logic [11:0] luma;
        logic [11:0] dec;
        load_pix  = '0;
        load_keep = '0;
        prod      = '0;
        luma      = '0;
        dec       = '0;
        for (int k = 0; k < 8; k++) begin
            luma = taps[32*k +: 12];
            prod = {3'b000, luma} * 15'(8 - k);
            dec  = prod[14:3];
            load_pix[k] = {taps[32*k+12 +: 20], dec};
`ifdef PHOSPHOR_SKIP_DIM_EN
            load_keep[k] = (dec >= LUMA_MIN);
`else
            load_keep[k] = (luma != 12'd0);
`endif
        end
    end

    // Next-state, mask and registered-output decode.
    always_comb begin
        state_d     = state_q;
        mask_d      = mask_q;
        pix_d       = pix_q;
        out_valid_d = out_valid;
        out_pixel_d = out_pixel;
        remain      = '0;
        unique case (state_q)
            IDLE: begin
                if (tap_valid) begin
                    pix_d  = load_pix;
                    mask_d = load_keep;
                    if (load_keep != 8'd0) begin
                        state_d     = EMIT;
                        out_valid_d = 1'b1;
                        out_pixel_d = load_pix[lowest(load_keep)];
                    end
                end
            end
            EMIT: begin
                if (handshake) begin
                    remain = mask_q & (mask_q - 8'd1);
                    mask_d = remain;
                    if (remain == 8'd0) begin
                        state_d     = IDLE;
                        out_valid_d = 1'b0;
                    end else begin
                        out_pixel_d = pix_q[lowest(remain)];
                    end
                end
            end
        endcase
    end

    // State, snapshot and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= IDLE;
            mask_q    <= '0;
            pix_q     <= '0;
            out_valid <= 1'b0;
            out_pixel <= '0;
        end else begin
            state_q   <= state_d;
            mask_q    <= mask_d;
            pix_q     <= pix_d;
            out_valid <= out_valid_d;
            out_pixel <= out_pixel_d;
        end
    end

    // Saturating count of snapshots offered while busy.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            drop_count <= '0;
        end else if (tap_valid && !tap_ready && (drop_count != '1)) begin
            drop_count <= drop_count + DROP_W'(1);
        end
    end

endmodule

// File: tb/tb_phosphor_tap_scheduler.sv
// tb_phosphor_tap_scheduler: directed and randomized snapshots checked
// against a queue-based model of the decay, skip and drop rules.
module tb_phosphor_tap_scheduler;

    logic         clock;
    logic         reset_n;
    logic [255:0] taps;
    logic         tap_valid;
    logic         tap_ready;
    logic [31:0]  out_pixel;
    logic         out_valid;
    logic         out_ready;
    logic [15:0]  drop_count;

    int           checks;
    int           failures;
    logic [15:0]  exp_drop;
    logic [31:0]  exp_q[$];

    phosphor_tap_scheduler #(
        .LUMA_MIN(12'd16),
        .DROP_W  (16)
    ) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .taps      (taps),
        .tap_valid (tap_valid),
        .tap_ready (tap_ready),
        .out_pixel (out_pixel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .drop_count(drop_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #5000000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] px(input int y, input int x, input int l);
        logic [31:0] p;
        p = {10'(y), 10'(x), 12'(l)};
        return p;
    endfunction

    function automatic logic [255:0] uniform(input int y, input int x, input int l);
        logic [255:0] t;
        for (int k = 0; k < 8; k++) t[32*k +: 32] = px(y, x, l);
        return t;
    endfunction

    function automatic logic [255:0] rand_taps();
        logic [255:0] t;
        int l;
        for (int k = 0; k < 8; k++) begin
            case ($urandom_range(0, 3))
                0: l = 0;
                1: l = $urandom_range(1, 200);
                default: l = $urandom_range(0, 4095);
            endcase
            t[32*k +: 32] = px($urandom_range(0, 1023), $urandom_range(0, 1023), l);
        end
        return t;
    endfunction

    // Expected beats: decayed luma = luma*(8-k)/8, ascending tap order.
    task automatic build_exp(input logic [255:0] t);
        int luma;
        int d;
        bit keep;
        exp_q.delete();
        for (int k = 0; k < 8; k++) begin
            luma = int'(t[32*k +: 12]);
            d = (luma * (8 - k)) / 8;
`ifdef PHOSPHOR_SKIP_DIM_EN
            keep = (d >= 16);
`else
            keep = (luma != 0);
`endif
            if (keep) exp_q.push_back({t[32*k+12 +: 20], 12'(d)});
        end
    endtask

    task automatic bump_drop();
        if (exp_drop != 16'hFFFF) exp_drop = exp_drop + 16'd1;
    endtask

    task automatic run_snapshot(input logic [255:0] t, input int stall_at,
                                input int stall_len, input int ndrop);
        build_exp(t);
        check("ready_before_load", 32'(tap_ready), 32'd1);
        taps = t;
        tap_valid = 1'b1;
        out_ready = 1'b1;
        step();
        tap_valid = 1'b0;
        taps = {8{$urandom}};
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i == stall_at) begin
                out_ready = 1'b0;
                for (int s = 0; s < stall_len; s++) begin
                    check("stall_valid", 32'(out_valid), 32'd1);
                    check("stall_pixel", out_pixel, exp_q[i]);
                    step();
                end
                out_ready = 1'b1;
            end
            check("beat_valid", 32'(out_valid), 32'd1);
            check("beat_pixel", out_pixel, exp_q[i]);
            check("busy_ready", 32'(tap_ready), 32'd0);
            if (i < ndrop) begin
                tap_valid = 1'b1;
                taps = {8{$urandom}};
                bump_drop();
            end
            step();
            tap_valid = 1'b0;
        end
        check("done_valid", 32'(out_valid), 32'd0);
        check("done_ready", 32'(tap_ready), 32'd1);
        check("drop_count", 32'(drop_count), 32'(exp_drop));
    endtask

    initial begin
        logic [255:0] t;
        int n;
        checks = 0;
        failures = 0;
        exp_drop = '0;
        out_ready = 1'b1;

        reset_n = 1'b0;
        tap_valid = 1'b1;
        taps = uniform(9, 5, 12'h800);
        repeat (3) step();
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_pixel", out_pixel, 32'd0);
        check("rst_drop", 32'(drop_count), 32'd0);
        tap_valid = 1'b0;
        reset_n = 1'b1;
        step();
        check("rst_ready", 32'(tap_ready), 32'd1);
        check("rst_idle_valid", 32'(out_valid), 32'd0);

        // Full snapshot, 8 back-to-back beats.
        run_snapshot(uniform(9, 5, 12'h800), 99, 0, 0);
        check("full_last_beat_luma", 32'(exp_q[7][11:0]), 32'h100);

        // Backpressure on beat 2 for 3 cycles.
        run_snapshot(uniform(9, 5, 12'h800), 1, 3, 0);
        check("bp_held_luma", 32'(exp_q[1][11:0]), 32'h700);

        // Taps 1 and 3 dark.
        t = uniform(9, 5, 12'h800);
        t[32*1 +: 12] = 12'h000;
        t[32*3 +: 12] = 12'h000;
        run_snapshot(t, 99, 0, 0);
        check("skip13_beats", exp_q.size(), 6);

        // Tap 7 dim: skipped only with the dim-skip build.
        t[32*7 +: 12] = 12'h07F;
        run_snapshot(t, 99, 0, 0);
`ifdef PHOSPHOR_SKIP_DIM_EN
        check("dim_beats", exp_q.size(), 5);
`else
        check("dim_beats", exp_q.size(), 6);
`endif

        // All dark: nothing emitted, no drop.
        run_snapshot(uniform(3, 4, 0), 99, 0, 0);
        step();
        check("empty_valid", 32'(out_valid), 32'd0);
        check("empty_ready", 32'(tap_ready), 32'd1);

        // Three drops during EMIT.
        run_snapshot(uniform(9, 5, 12'h800), 99, 0, 3);
        check("drop3", 32'(drop_count), 32'd3);

        // Randomized snapshots.
        for (int r = 0; r < 40; r++) begin
            run_snapshot(rand_taps(), $urandom_range(0, 8),
                         $urandom_range(1, 4), $urandom_range(0, 3));
        end

        // Mid-stream reset at beat 4.
        build_exp(uniform(9, 5, 12'h800));
        taps = uniform(9, 5, 12'h800);
        tap_valid = 1'b1;
        out_ready = 1'b1;
        step();
        tap_valid = 1'b0;
        repeat (3) step();
        check("mid_beat4", out_pixel, exp_q[3]);
        #1;
        reset_n = 1'b0;
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_pixel", out_pixel, 32'd0);
        check("mid_rst_drop", 32'(drop_count), 32'd0);
        exp_drop = '0;
        step();
        step();
        reset_n = 1'b1;
        for (int i = 0; i < 3; i++) begin
            step();
            check("post_rst_valid", 32'(out_valid), 32'd0);
            check("post_rst_ready", 32'(tap_ready), 32'd1);
        end
        run_snapshot(rand_taps(), 99, 0, 0);
        run_snapshot(uniform(1, 2, 12'hFFF), 99, 0, 1);

        // Drop counter saturation under long backpressure.
        build_exp(uniform(7, 7, 12'h800));
        taps = uniform(7, 7, 12'h800);
        tap_valid = 1'b1;
        out_ready = 1'b0;
        step();
        n = 65535 - int'(exp_drop);
        for (int i = 0; i < n; i++) step();
        check("sat_reach", 32'(drop_count), 32'h0000FFFF);
        step();
        step();
        check("sat_hold", 32'(drop_count), 32'h0000FFFF);
        check("sat_pixel", out_pixel, exp_q[0]);
        tap_valid = 1'b0;
        out_ready = 1'b1;
        for (int i = 0; i < exp_q.size(); i++) begin
            check("sat_beat", out_pixel, exp_q[i]);
            step();
        end
        check("sat_done_ready", 32'(tap_ready), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
